icache_direct: RTL and testbench
================================

# icache_direct

Direct-mapped, read-only instruction cache placed between the pipelined datapath's fetch port and the memory arbiter. Serves `imemaddr` hits combinationally with `ihit`. On a miss it runs a single-word fill over the `iREN`/`iwait`/`iload` memory handshake, then returns to lookup. The datapath advances its PC only on `ihit`, so the fetch address is held stable by the pipeline during a fill.

## Interface
Parameters:
- SETS, 16, number of one-word frames; must be a power of two, at least 2.
- IDX_W, $clog2(SETS), index width.
- TAG_W, 30 - IDX_W, tag width.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- nRST  input  1  reset. One clock; reset is synchronous and active-high. The name is kept for codebase consistency; it is active-high despite the name.
- imemREN  input  1  datapath fetch request.
- imemaddr  input  32  fetch byte address; bits [1:0] are ignored.
- ihit  output  1  hit; `imemload` is valid this cycle.
- imemload  output  32  instruction word.
- iREN  output  1  memory read request.
- iaddr  output  32  memory word address, with bits [1:0] forced to 0.
- iwait  input  1  memory busy; `iload` is valid in a cycle where `iREN`=1 and `iwait`=0.
- iload  input  32  memory read data.
- hit_count  output  32  present only with ICACHE_STATS_EN.
- miss_count  output  32  present only with ICACHE_STATS_EN.

## Operation
Address fields:
- index = imemaddr[IDX_W+1:2]
- tag = imemaddr[31:IDX_W+2]

Storage: per frame, one valid bit, a TAG_W-bit tag and a 32-bit data word.

States:
- IDLE (lookup)
  - Compute `match` = valid[index] && tag[index]==tag.
  - `ihit` = imemREN && match.
  - `imemload` = data[index] when `ihit`, otherwise 32'h0.
  - If imemREN && !match: latch imemaddr[31:2] into `fill_addr` and go to FETCH.
  - If imemREN=0: stay in IDLE; ihit=0.
- FETCH
  - iREN=1; iaddr={fill_addr,2'b00}; ihit=0; imemload=0.
  - If iwait=0: write iload to data[fill index], write tag, set valid, go to IDLE.
  - If iwait=1: stay in FETCH.

Rules:
- A fill always completes once started, even if imemREN drops or imemaddr changes mid-fill. The filled frame is the one selected by the latched `fill_addr`.
- A new address presented after the fill is looked up normally in IDLE.
- Conflict eviction: a fill overwrites the frame unconditionally. No dirty state exists, since the cache is read-only.
- No allocation or memory request occurs when imemREN=0.

Reset, applied when nRST=1 at an edge:
- state=IDLE
- all valid bits=0
- fill_addr=0
- counters=0

Output values during and after reset: iREN=0, iaddr=0, ihit=0, imemload=0. Tag and data arrays need not be reset.

Reset mid-FETCH aborts the fill: no frame is written and iREN drops in the cycle after the reset edge.

## Timing
- Hit latency is 0 cycles: `ihit` is asserted combinationally in the same cycle the address is presented.
- Miss timeline:
  - Cycle 0: miss detected in IDLE.
  - Cycles 1..N: FETCH, with iREN high. N = 1 + the number of cycles iwait stays high.
  - At the edge ending cycle N, the frame is written.
  - Cycle N+1: IDLE; `ihit`=1 for the same address.
- Minimum miss-to-hit time, with iwait=0 immediately, is 2 cycles.
- `iREN` and `iaddr` are decoded from registered state and `fill_addr` only, so they are glitch-free with respect to imemaddr.
- No combinational path exists from iload to ihit.

## Configuration
- ICACHE_STATS_EN defined:
  - Adds `hit_count` and `miss_count` as 32-bit saturating counters.
  - `hit_count` increments on each cycle with ihit=1.
  - `miss_count` increments on each IDLE→FETCH transition.
  - Both clear on reset and hold at 32'hFFFFFFFF.
- ICACHE_STATS_EN undefined: the two ports and the counters are absent. All other behaviour is identical.

## Test plan
- Reset, then imemREN=1, imemaddr=0x0 -> ihit=0. Next cycle iREN=1, iaddr=0x0. With iwait=0 and iload=0x2001000A: the cycle after, ihit=1 and imemload=0x2001000A.
- Refill, then re-read 0x0 for 3 cycles -> ihit=1 each cycle, iREN=0 throughout; hit_count=3 (stats build).
- Conflict (SETS=16): fill 0x0, then fill 0x40 -> 0x40 hits. Re-reading 0x0 misses, with iaddr=0x0 and miss_count incremented.
- iwait held high 5 cycles during FETCH for 0x8 -> iREN stays 1 and iaddr stays 0x8 for 6 cycles, ihit=0 throughout; ihit=1 one cycle after iwait falls.
- Mid-fill address change from 0xC to 0x10 while iwait=1 -> iaddr stays 0xC and the 0xC frame fills. Then 0x10 misses and fills separately.
- nRST=1 asserted during FETCH -> next cycle iREN=0 and ihit=0. A subsequent read of the aborted address misses.

Source files
------------

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache between the fetch
// port and the memory arbiter. Hits are served combinationally. A miss latches
// the word address and runs a single-word fill over the iREN/iwait/iload
// handshake. Once started, a fill always completes unless reset aborts it.
//
// Ports:
//   CLK        clock, rising edge
//   nRST       synchronous reset, active-high despite the name
//   imemREN    fetch request
//   imemaddr   fetch byte address; bits [1:0] are ignored
//   ihit       hit; imemload is valid this cycle
//   imemload   instruction word; zero when there is no hit
//   iREN       memory read request
//   iaddr      memory word address; zero when idle
//   iwait      memory busy
//   iload      memory read data
//   hit_count  saturating count of hit cycles     (ICACHE_STATS_EN only)
//   miss_count saturating count of fills started  (ICACHE_STATS_EN only)
//
// Optional feature: define ICACHE_STATS_EN to add the two statistics counters.

module icache_direct #(
    parameter int unsigned SETS  = 16,
    parameter int unsigned IDX_W = $clog2(SETS),
    parameter int unsigned TAG_W = 30 - IDX_W
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    typedef enum logic {StIdle, StFetch} state_e;

    state_e            state_q;
    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [31:0]       data_q [SETS];
    logic [29:0]       fill_addr_q;
    logic              iren_q;
    logic [31:0]       iaddr_q;

    logic [IDX_W-1:0]  lookup_idx;
    logic [TAG_W-1:0]  lookup_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              match;
    logic              miss_start;

    // Byte-offset bits never take part in lookup.
    logic unused_addr_bits;
    assign unused_addr_bits = ^imemaddr[1:0];

    assign lookup_idx = imemaddr[IDX_W+1:2];
    assign lookup_tag = imemaddr[31:IDX_W+2];
    assign fill_idx   = fill_addr_q[IDX_W-1:0];
    assign fill_tag   = fill_addr_q[29:IDX_W];

    assign match      = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
    assign miss_start = (state_q == StIdle) && imemREN && !match;

    // Gated by nRST so nothing is reported as a hit during the reset cycle.
    always_comb begin
        ihit     = (state_q == StIdle) && imemREN && match && !nRST;
        imemload = ihit ? data_q[lookup_idx] : 32'h0;
    end

    // iREN/iaddr come straight from flops, so they never glitch with imemaddr.
    assign iREN  = iren_q;
    assign iaddr = iaddr_q;

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q     <= StIdle;
            valid_q     <= '0;
            fill_addr_q <= '0;
            iren_q      <= 1'b0;
            iaddr_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (miss_start) begin
                        fill_addr_q <= imemaddr[31:2];
                        iren_q      <= 1'b1;
                        iaddr_q     <= {imemaddr[31:2], 2'b00};
                        state_q     <= StFetch;
                    end
                end
                StFetch: begin
                    // Frame chosen by the latched address, not the live one.
                    if (!iwait) begin
                        data_q[fill_idx]  <= iload;
                        tag_q[fill_idx]   <= fill_tag;
                        valid_q[fill_idx] <= 1'b1;
                        iren_q            <= 1'b0;
                        iaddr_q           <= '0;
                        state_q           <= StIdle;
                    end
                end
                default: begin
                    iren_q  <= 1'b0;
                    iaddr_q <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    always_ff @(posedge CLK) begin
        if (nRST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (ihit && (hit_count_q != 32'hFFFF_FFFF)) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if (miss_start && (miss_count_q != 32'hFFFF_FFFF)) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct. Inputs change 1 time unit after the rising
// edge; outputs are compared a further time unit later, well clear of the edge.

module tb_icache_direct;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_vec;
    int n_err;

    icache_direct #(.SETS(16)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        nRST     = 1'b1;
        imemREN  = 1'b0;
        imemaddr = 32'h0;
        iwait    = 1'b0;
        iload    = 32'h0;

        tick();
        tick();
        #1;
        check("rst_iren", {31'b0, iREN}, 32'h0);
        check("rst_iaddr", iaddr, 32'h0);
        check("rst_ihit", {31'b0, ihit}, 32'h0);
        check("rst_imemload", imemload, 32'h0);
        nRST = 1'b0;

        // No request: no allocation.
        imemaddr = 32'h24;
        tick();
        #1;
        check("noreq_iren", {31'b0, iREN}, 32'h0);

        // Cold miss on 0x0, immediate fill.
        imemREN  = 1'b1;
        imemaddr = 32'h0;
        #1;
        check("miss0_ihit", {31'b0, ihit}, 32'h0);
        tick();
        iload = 32'h2001_000A;
        #1;
        check("fill0_iren", {31'b0, iREN}, 32'h1);
        check("fill0_iaddr", iaddr, 32'h0);
        check("fill0_ihit", {31'b0, ihit}, 32'h0);
        tick();
        #1;
        // Repeated hits on 0x0.
        for (int i = 0; i < 3; i++) begin
            check("hit0_ihit", {31'b0, ihit}, 32'h1);
            check("hit0_load", imemload, 32'h2001_000A);
            check("hit0_iren", {31'b0, iREN}, 32'h0);
            tick();
            #1;
        end
        imemREN = 1'b0;
        #1;
        check("idle_ihit", {31'b0, ihit}, 32'h0);
        check("idle_load", imemload, 32'h0);
`ifdef ICACHE_STATS_EN
        check("hit_count3", hit_count, 32'd3);
        check("miss_count1", miss_count, 32'd1);
`endif

        // Conflict: 0x40 shares frame 0 with 0x0.
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        iload    = 32'hAAAA_0040;
        #1;
        check("miss40_ihit", {31'b0, ihit}, 32'h0);
        tick();
        #1;
        check("fill40_iaddr", iaddr, 32'h40);
        tick();
        #1;
        check("hit40_ihit", {31'b0, ihit}, 32'h1);
        check("hit40_load", imemload, 32'hAAAA_0040);
        tick();
        imemaddr = 32'h0;
        iload    = 32'h2001_000A;
        #1;
        check("evict0_ihit", {31'b0, ihit}, 32'h0);
        tick();
        #1;
        check("refill0_iren", {31'b0, iREN}, 32'h1);
        check("refill0_iaddr", iaddr, 32'h0);
`ifdef ICACHE_STATS_EN
        check("miss_count3", miss_count, 32'd3);
`endif
        tick();
        #1;
        check("rehit0_load", imemload, 32'h2001_000A);

        // Stalled fill of 0x8: iwait high for 5 FETCH cycles.
        imemaddr = 32'h8;
        iwait    = 1'b1;
        iload    = 32'h8888_0008;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_iren", {31'b0, iREN}, 32'h1);
            check("stall_iaddr", iaddr, 32'h8);
            check("stall_ihit", {31'b0, ihit}, 32'h0);
            tick();
        end
        iwait = 1'b0;
        #1;
        check("stall6_iren", {31'b0, iREN}, 32'h1);
        check("stall6_iaddr", iaddr, 32'h8);
        tick();
        #1;
        check("hit8_ihit", {31'b0, ihit}, 32'h1);
        check("hit8_load", imemload, 32'h8888_0008);

        // Address moves from 0xC to 0x10 mid-fill.
        imemaddr = 32'hC;
        iwait    = 1'b1;
        iload    = 32'hCCCC_000C;
        tick();
        imemaddr = 32'h10;
        #1;
        check("move_iaddr", iaddr, 32'hC);
        check("move_ihit", {31'b0, ihit}, 32'h0);
        tick();
        iwait = 1'b0;
        #1;
        check("move_iaddr2", iaddr, 32'hC);
        tick();
        iload = 32'h1010_0010;
        #1;
        check("miss10_ihit", {31'b0, ihit}, 32'h0);
        tick();
        #1;
        check("fill10_iaddr", iaddr, 32'h10);
        tick();
        #1;
        check("hit10_load", imemload, 32'h1010_0010);
        imemaddr = 32'hC;
        #1;
        check("hitC_ihit", {31'b0, ihit}, 32'h1);
        check("hitC_load", imemload, 32'hCCCC_000C);

        // Reset during FETCH aborts the fill of 0x14.
        tick();
        imemaddr = 32'h14;
        iwait    = 1'b1;
        iload    = 32'h1414_0014;
        tick();
        #1;
        check("abort_iren_pre", {31'b0, iREN}, 32'h1);
        nRST = 1'b1;
        tick();
        nRST  = 1'b0;
        iwait = 1'b0;
        #1;
        check("abort_iren", {31'b0, iREN}, 32'h0);
        check("abort_ihit", {31'b0, ihit}, 32'h0);
        tick();
        #1;
        check("abort_refetch_iren", {31'b0, iREN}, 32'h1);
        check("abort_refetch_iaddr", iaddr, 32'h14);
        tick();
        imemaddr = 32'h8;
        #1;
        check("post_rst_8_ihit", {31'b0, ihit}, 32'h0);
`ifdef ICACHE_STATS_EN
        check("post_rst_miss", miss_count, 32'd1);
`endif

        imemREN = 1'b0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
